// File: rtl/hazard_control_unit_pkg.sv
// Shared encodings for the ID-stage hazard/sequencing logic: branch flags, PC select, FSM states.
package hazard_control_unit_pkg;

  typedef enum logic [2:0] {
    FLAG_NONE = 3'b000,
    FLAG_JR   = 3'b001,
    FLAG_JALR = 3'b010,
    FLAG_BEQ  = 3'b011,
    FLAG_BNE  = 3'b100,
    FLAG_JUMP = 3'b101
  } flag_e;

  localparam logic [1:0] PC_SEL_PC4    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_REG    = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam int CANT_CICLOS_DRAIN_DEF = 3;

  // Branches resolved in ID read register operands and so can stall on producers in EX/MEM.
  function automatic logic flag_reads_regs(input logic [2:0] flag);
    return (flag == FLAG_JR) || (flag == FLAG_JALR) || (flag == FLAG_BEQ) || (flag == FLAG_BNE);
  endfunction

endpackage

// File: rtl/hazard_control_unit_hazard_detector.sv
// Combinational register-match logic: load-use and ID-branch operand hazards. Register 0 never matches.
module hazard_detector
  import hazard_control_unit_pkg::*;
#(
  parameter int CANT_BITS_ADDRESS_REGISTROS = 5,
  parameter int CANT_BITS_FLAG_BRANCH       = 3
) (
  input  logic [CANT_BITS_FLAG_BRANCH-1:0]       flag_branch_i,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] reg_a_i,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] reg_b_i,
  input  logic                                   uses_b_i,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] ex_reg_w_i,
  input  logic                                   ex_reg_write_i,
  input  logic                                   ex_mem_read_i,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] mem_reg_w_i,
  input  logic                                   mem_mem_read_i,
  output logic                                   hazard_o
);

  function automatic logic reg_match(input logic [CANT_BITS_ADDRESS_REGISTROS-1:0] src,
                                     input logic [CANT_BITS_ADDRESS_REGISTROS-1:0] dst);
    return (src == dst) && (src != '0);
  endfunction

  logic src_hits_ex;
  logic src_hits_mem;
  logic load_use;
  logic branch_operand;

  always_comb begin
    src_hits_ex    = reg_match(reg_a_i, ex_reg_w_i)  || (uses_b_i && reg_match(reg_b_i, ex_reg_w_i));
    src_hits_mem   = reg_match(reg_a_i, mem_reg_w_i) || (uses_b_i && reg_match(reg_b_i, mem_reg_w_i));
    load_use       = ex_mem_read_i && src_hits_ex;
    // A load in EX stalls here once, then again from MEM on the following cycle.
    branch_operand = flag_reads_regs(flag_branch_i[2:0]) &&
                     ((ex_reg_write_i && src_hits_ex) || (mem_mem_read_i && src_hits_mem));
    hazard_o       = load_use || branch_operand;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stall/flush/bubble/PC-select from ID hazards, HALT drain FSM, stall counter.
// Optional macro BRANCH_DELAY_SLOT_EN suppresses the IF/ID flush on taken transfers.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CANT_BITS_ADDRESS_REGISTROS = 5,
  parameter int CANT_BITS_FLAG_BRANCH       = 3,
  parameter int CANT_BITS_CONTADOR          = 32,
  parameter int CANT_CICLOS_DRAIN           = CANT_CICLOS_DRAIN_DEF
) (
  input  logic                                   i_clock,
  input  logic                                   i_reset,
  input  logic                                   i_enable,
  input  logic [CANT_BITS_FLAG_BRANCH-1:0]       i_flag_branch,
  input  logic                                   i_branch_equal,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_reg_A,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_reg_B,
  input  logic                                   i_uses_B,
  input  logic                                   i_halt_id,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_ex_reg_W,
  input  logic                                   i_ex_reg_write,
  input  logic                                   i_ex_mem_read,
  input  logic [CANT_BITS_ADDRESS_REGISTROS-1:0] i_mem_reg_W,
  input  logic                                   i_mem_mem_read,
  output logic                                   o_stall_pc,
  output logic                                   o_stall_if_id,
  output logic                                   o_flush_if_id,
  output logic                                   o_bubble_id_ex,
  output logic [1:0]                             o_pc_select,
  output logic                                   o_halted,
  output logic [CANT_BITS_CONTADOR-1:0]          o_stall_cycles
);

  localparam int DRAIN_W = (CANT_CICLOS_DRAIN < 1) ? 1 : $clog2(CANT_CICLOS_DRAIN + 1);

  state_e                        state_q, state_d;
  logic [DRAIN_W-1:0]            drain_q, drain_d;
  logic [CANT_BITS_CONTADOR-1:0] stall_cnt_q, stall_cnt_d;
  logic                          hazard;
  logic [1:0]                    pc_sel_raw;

  hazard_detector #(
    .CANT_BITS_ADDRESS_REGISTROS(CANT_BITS_ADDRESS_REGISTROS),
    .CANT_BITS_FLAG_BRANCH      (CANT_BITS_FLAG_BRANCH)
  ) u_hazard_detector (
    .flag_branch_i  (i_flag_branch),
    .reg_a_i        (i_reg_A),
    .reg_b_i        (i_reg_B),
    .uses_b_i       (i_uses_B),
    .ex_reg_w_i     (i_ex_reg_W),
    .ex_reg_write_i (i_ex_reg_write),
    .ex_mem_read_i  (i_ex_mem_read),
    .mem_reg_w_i    (i_mem_reg_W),
    .mem_mem_read_i (i_mem_mem_read),
    .hazard_o       (hazard)
  );

  always_comb begin
    pc_sel_raw = PC_SEL_PC4;
    case (i_flag_branch[2:0])
      FLAG_BEQ:          pc_sel_raw = i_branch_equal ? PC_SEL_BRANCH : PC_SEL_PC4;
      FLAG_BNE:          pc_sel_raw = i_branch_equal ? PC_SEL_PC4 : PC_SEL_BRANCH;
      FLAG_JUMP:         pc_sel_raw = PC_SEL_JUMP;
      FLAG_JR, FLAG_JALR: pc_sel_raw = PC_SEL_REG;
      default:           pc_sel_raw = PC_SEL_PC4;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    stall_cnt_d    = stall_cnt_q;
    o_stall_pc     = 1'b0;
    o_stall_if_id  = 1'b0;
    o_flush_if_id  = 1'b0;
    o_bubble_id_ex = 1'b0;
    o_pc_select    = PC_SEL_PC4;
    o_halted       = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          o_stall_pc     = 1'b1;
          o_stall_if_id  = 1'b1;
          o_bubble_id_ex = 1'b1;
          if (i_enable) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
          o_pc_select = pc_sel_raw;
`ifdef BRANCH_DELAY_SLOT_EN
          o_flush_if_id = 1'b0;
`else
          o_flush_if_id = (pc_sel_raw != PC_SEL_PC4);
`endif
          if (i_halt_id && i_enable) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_W'(CANT_CICLOS_DRAIN);
          end
        end
      end
      ST_DRAIN: begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_bubble_id_ex = 1'b1;
        if (i_enable) begin
          if (drain_q <= DRAIN_W'(1)) begin
            state_d = ST_HALTED;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DRAIN_W'(1);
          end
        end
      end
      ST_HALTED: begin
        o_stall_pc     = 1'b1;
        o_stall_if_id  = 1'b1;
        o_bubble_id_ex = 1'b1;
        o_halted       = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    // Reset forces a quiet pipeline even while the live ID inputs still show a hazard.
    if (i_reset) begin
      o_stall_pc     = 1'b0;
      o_stall_if_id  = 1'b0;
      o_flush_if_id  = 1'b0;
      o_bubble_id_ex = 1'b0;
      o_pc_select    = PC_SEL_PC4;
      o_halted       = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit; inputs driven on negedge, outputs checked 2ns later.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst, en, br_eq, uses_b, halt_id;
  logic [2:0]  flag;
  logic [4:0]  reg_a, reg_b, ex_w, mem_w;
  logic        ex_wr, ex_ld, mem_ld;
  logic        stall_pc, stall_if_id, flush, bubble, halted;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cycles;
  logic [6:0]  outs;

  int vecs = 0;
  int errs = 0;
  logic [31:0] exp_cnt;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic FL = 1'b0;
`else
  localparam logic FL = 1'b1;
`endif
  localparam logic [6:0] O_IDLE   = 7'b000_0_00_0;
  localparam logic [6:0] O_STALL  = 7'b111_0_00_0;
  localparam logic [6:0] O_HALTED = 7'b111_0_00_1;
  localparam logic [6:0] O_BR     = {3'b000, FL, 2'b01, 1'b0};
  localparam logic [6:0] O_JMP    = {3'b000, FL, 2'b10, 1'b0};
  localparam logic [6:0] O_REG    = {3'b000, FL, 2'b11, 1'b0};

  always #5 clk = ~clk;

  assign outs = {stall_pc, stall_if_id, bubble, flush, pc_sel, halted};

  hazard_control_unit dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_flag_branch(flag),
    .i_branch_equal(br_eq), .i_reg_A(reg_a), .i_reg_B(reg_b), .i_uses_B(uses_b),
    .i_halt_id(halt_id), .i_ex_reg_W(ex_w), .i_ex_reg_write(ex_wr),
    .i_ex_mem_read(ex_ld), .i_mem_reg_W(mem_w), .i_mem_mem_read(mem_ld),
    .o_stall_pc(stall_pc), .o_stall_if_id(stall_if_id), .o_flush_if_id(flush),
    .o_bubble_id_ex(bubble), .o_pc_select(pc_sel), .o_halted(halted),
    .o_stall_cycles(stall_cycles)
  );

  task automatic idle();
    en = 1'b1; flag = 3'b000; br_eq = 1'b0; reg_a = '0; reg_b = '0; uses_b = 1'b0;
    halt_id = 1'b0; ex_w = '0; ex_wr = 1'b0; ex_ld = 1'b0; mem_w = '0; mem_ld = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd5; reg_a = 5'd5;
    #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL reset_forced outs=%b exp=%b", outs, O_IDLE); end
    step(); idle(); #2;
    vecs++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
    step(); rst = 1'b0; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL reset_idle outs=%b exp=%b", outs, O_IDLE); end
    exp_cnt = 0;
    step();
  endtask

  task automatic test_load_use();
    idle(); ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd5; reg_a = 5'd5; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL load_use_stall outs=%b exp=%b", outs, O_STALL); end
    step(); exp_cnt++;
    ex_ld = 1'b0; ex_wr = 1'b0; ex_w = '0; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL load_use_release outs=%b exp=%b", outs, O_IDLE); end
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL load_use_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    step();
  endtask

  task automatic test_uses_b();
    idle(); ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd7; reg_a = 5'd2; reg_b = 5'd7; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL rt_unused outs=%b exp=%b", outs, O_IDLE); end
    step(); uses_b = 1'b1; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL rt_used outs=%b exp=%b", outs, O_STALL); end
    step(); exp_cnt++; idle(); #2;
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL rt_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    step();
  endtask

  task automatic test_zero_reg();
    idle(); ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd0; reg_a = 5'd0; reg_b = 5'd0; uses_b = 1'b1;
    flag = 3'b011; mem_w = 5'd0; mem_ld = 1'b1; br_eq = 1'b0; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL zero_reg outs=%b exp=%b", outs, O_IDLE); end
    step(); idle(); #2;
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL zero_reg_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    step();
  endtask

  task automatic test_branch_load();
    idle(); flag = 3'b011; br_eq = 1'b1; reg_a = 5'd3; reg_b = 5'd4; uses_b = 1'b1;
    ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd4; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL beq_ld_c1 outs=%b exp=%b", outs, O_STALL); end
    step(); exp_cnt++;
    ex_ld = 1'b0; ex_wr = 1'b0; ex_w = '0; mem_w = 5'd4; mem_ld = 1'b1; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL beq_ld_c2 outs=%b exp=%b", outs, O_STALL); end
    step(); exp_cnt++;
    mem_ld = 1'b0; mem_w = '0; #2;
    vecs++; if (outs !== O_BR) begin errs++; $display("FAIL beq_ld_taken outs=%b exp=%b", outs, O_BR); end
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL beq_ld_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    step();
  endtask

  task automatic test_branch_alu();
    idle(); flag = 3'b100; br_eq = 1'b0; reg_a = 5'd3; reg_b = 5'd9; uses_b = 1'b1;
    ex_wr = 1'b1; ex_w = 5'd9; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL bne_alu_stall outs=%b exp=%b", outs, O_STALL); end
    step(); exp_cnt++;
    ex_wr = 1'b0; ex_w = '0; mem_w = 5'd9; #2;
    vecs++; if (outs !== O_BR) begin errs++; $display("FAIL bne_alu_taken outs=%b exp=%b", outs, O_BR); end
    step(); idle(); reg_a = 5'd9; ex_wr = 1'b1; ex_w = 5'd9; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL alu_fwd_nostall outs=%b exp=%b", outs, O_IDLE); end
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL bne_alu_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    step();
  endtask

  task automatic test_transfers();
    idle(); flag = 3'b100; br_eq = 1'b1; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL bne_not_taken outs=%b exp=%b", outs, O_IDLE); end
    step(); flag = 3'b001; reg_a = 5'd31; br_eq = 1'b0; #2;
    vecs++; if (outs !== O_REG) begin errs++; $display("FAIL jr outs=%b exp=%b", outs, O_REG); end
    step(); flag = 3'b010; #2;
    vecs++; if (outs !== O_REG) begin errs++; $display("FAIL jalr outs=%b exp=%b", outs, O_REG); end
    step(); flag = 3'b101; #2;
    vecs++; if (outs !== O_JMP) begin errs++; $display("FAIL jump outs=%b exp=%b", outs, O_JMP); end
    step(); flag = 3'b011; br_eq = 1'b0; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL beq_not_taken outs=%b exp=%b", outs, O_IDLE); end
    step(); idle(); #2;
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL transfer_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    step();
  endtask

  task automatic test_enable_freeze();
    idle(); en = 1'b0; ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd6; reg_a = 5'd6; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL freeze_comb outs=%b exp=%b", outs, O_STALL); end
    step(); step(); #2;
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL freeze_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    idle(); halt_id = 1'b1; en = 1'b0;
    step(); halt_id = 1'b0; en = 1'b1; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL freeze_halt_ignored outs=%b exp=%b", outs, O_IDLE); end
    step();
  endtask

  task automatic test_halt();
    idle(); halt_id = 1'b1; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL halt_accept outs=%b exp=%b", outs, O_IDLE); end
    for (int k = 1; k <= 3; k++) begin
      step(); halt_id = 1'b0; #2;
      vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL halt_drain_t%0d outs=%b exp=%b", k, outs, O_STALL); end
    end
    step(); #2;
    vecs++; if (outs !== O_HALTED) begin errs++; $display("FAIL halt_t4 outs=%b exp=%b", outs, O_HALTED); end
    step(); flag = 3'b101; #2;
    vecs++; if (outs !== O_HALTED) begin errs++; $display("FAIL halt_sticky outs=%b exp=%b", outs, O_HALTED); end
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL halt_drain_uncounted got=%0d exp=%0d", stall_cycles, exp_cnt); end
    idle(); rst = 1'b1; step(); rst = 1'b0; exp_cnt = 0; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL halt_reset outs=%b exp=%b", outs, O_IDLE); end
    step();
  endtask

  task automatic test_halt_pause();
    idle(); halt_id = 1'b1;
    step(); halt_id = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      en = (k == 2 || k == 3) ? 1'b0 : 1'b1; #2;
      vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL pause_drain_t%0d outs=%b exp=%b", k, outs, O_STALL); end
      step();
    end
    en = 1'b1; #2;
    vecs++; if (outs !== O_HALTED) begin errs++; $display("FAIL pause_halt_t6 outs=%b exp=%b", outs, O_HALTED); end
    rst = 1'b1; step(); rst = 1'b0; exp_cnt = 0;
  endtask

  task automatic test_hazard_halt();
    idle(); halt_id = 1'b1; ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd8; reg_a = 5'd8; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL hz_halt_stall outs=%b exp=%b", outs, O_STALL); end
    step(); exp_cnt++; ex_ld = 1'b0; ex_wr = 1'b0; ex_w = '0; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL hz_halt_accept outs=%b exp=%b", outs, O_IDLE); end
    vecs++; if (stall_cycles !== exp_cnt) begin errs++; $display("FAIL hz_halt_cnt got=%0d exp=%0d", stall_cycles, exp_cnt); end
    step(); halt_id = 1'b0; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL hz_halt_drain outs=%b exp=%b", outs, O_STALL); end
    step(); step(); #2;
    vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL hz_halt_t3 halted=%b exp=0", halted); end
    step(); #2;
    vecs++; if (outs !== O_HALTED) begin errs++; $display("FAIL hz_halt_t4 outs=%b exp=%b", outs, O_HALTED); end
    step();
  endtask

  task automatic test_reset_drain();
    idle(); rst = 1'b1; step(); rst = 1'b0; exp_cnt = 0;
    ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd5; reg_a = 5'd5;
    step(); idle(); halt_id = 1'b1;
    step(); halt_id = 1'b0; #2;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL rd_in_drain outs=%b exp=%b", outs, O_STALL); end
    vecs++; if (stall_cycles !== 32'd1) begin errs++; $display("FAIL rd_pre_cnt got=%0d exp=1", stall_cycles); end
    rst = 1'b1;
    step(); rst = 1'b0; #2;
    vecs++; if (outs !== O_IDLE) begin errs++; $display("FAIL rd_run outs=%b exp=%b", outs, O_IDLE); end
    vecs++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL rd_cnt got=%0d exp=0", stall_cycles); end
    ex_ld = 1'b1; ex_wr = 1'b1; ex_w = 5'd5; reg_a = 5'd5; #1;
    vecs++; if (outs !== O_STALL) begin errs++; $display("FAIL rd_live outs=%b exp=%b", outs, O_STALL); end
    step(); idle();
  endtask

  initial begin
    idle(); rst = 1'b1; exp_cnt = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_uses_b();
    test_zero_reg();
    test_branch_load();
    test_branch_alu();
    test_transfers();
    test_enable_freeze();
    test_halt();
    test_halt_pause();
    test_hazard_halt();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline sequencer for the MIPS core. It sits beside the ID stage and consumes the decoder's source and destination register addresses and branch flag, plus EX/MEM stage status. From these it drives PC hold, IF/ID hold and flush, ID/EX bubble insertion and PC source selection. It also drains the pipeline on HALT and counts hazard stall cycles for the debug unit.

## Interface
- CANT_BITS_ADDRESS_REGISTROS, 5, register address width
- CANT_BITS_FLAG_BRANCH, 3, decoder branch flag width
- CANT_BITS_CONTADOR, 32, stall counter width
- CANT_CICLOS_DRAIN, 3, bubbles needed to retire EX/MEM/WB after HALT
- i_clock  in  1  rising-edge clock
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  pipeline step enable from debug unit; low = freeze FSM and counters
- i_flag_branch  in  3  ID flag: 000 none, 001 JR, 010 JALR, 011 BEQ, 100 BNE, 101 J/JAL
- i_branch_equal  in  1  ID comparator result, rs == rt
- i_reg_A  in  5  ID rs address
- i_reg_B  in  5  ID rt address
- i_uses_B  in  1  ID instruction reads rt
- i_halt_id  in  1  HALT instruction in ID
- i_ex_reg_W  in  5  EX destination register
- i_ex_reg_write  in  1  EX writes register file
- i_ex_mem_read  in  1  EX instruction is a load
- i_mem_reg_W  in  5  MEM destination register
- i_mem_mem_read  in  1  MEM instruction is a load
- o_stall_pc  out  1  hold PC
- o_stall_if_id  out  1  hold IF/ID register
- o_flush_if_id  out  1  replace IF/ID with NOP
- o_bubble_id_ex  out  1  load NOP into ID/EX
- o_pc_select  out  2  00 PC+4, 01 branch target, 10 jump index, 11 register (JR/JALR)
- o_halted  out  1  pipeline drained after HALT
- o_stall_cycles  out  32  hazard stall cycles counted

## Operation
- States: RUN, DRAIN, HALTED. Reset enters RUN, clears the counters and drives every output to 0 (o_pc_select = 00).
- Hazard detection is combinational from live inputs in RUN. Register 0 never matches.
- Load-use hazard: i_ex_mem_read and i_ex_reg_W equal to i_reg_A, or to i_reg_B with i_uses_B.
- Branch-operand hazard applies when the flag is 001–100 and a source matches:
  - EX destination with i_ex_reg_write: stall.
  - MEM destination with i_mem_mem_read: stall.
  - A load in EX gives 2 stall cycles in total, because re-evaluation catches it again in MEM.
- On hazard: o_stall_pc = o_stall_if_id = o_bubble_id_ex = 1. o_pc_select = 00, no flush, halt ignored.
- With no hazard, o_pc_select follows the flag:
  - 011 with i_branch_equal, or 100 without it: select 01.
  - 101: select 10.
  - 001 or 010: select 11.
  - Otherwise: select 00.
  - Any select other than 00 = taken transfer: o_flush_if_id = 1 (see Configuration).
- RUN, no hazard, i_halt_id, i_enable: next state DRAIN and drain counter loads CANT_CICLOS_DRAIN.
- DRAIN: o_stall_pc = o_stall_if_id = o_bubble_id_ex = 1. Counter decrements per enabled cycle; at 1→0 the next state is HALTED.
- HALTED: same holds asserted, o_halted = 1. Sticky until i_reset.
- o_stall_cycles increments by 1 per enabled RUN cycle with a hazard and wraps at 2^32. Drain cycles are not counted.
- i_enable low: state, drain counter and o_stall_cycles hold. Combinational outputs still reflect inputs.

## Timing
- Hazard, flush and pc_select outputs are zero-latency combinational, valid in the same cycle as the ID inputs.
- o_halted rises CANT_CICLOS_DRAIN + 1 enabled cycles after the cycle that accepted i_halt_id. The drain sequence is 1 accept cycle, 3 DRAIN cycles, then HALTED.
- Reset asserted mid-DRAIN or in HALTED: RUN on the next edge, counters cleared.
- Hazard and HALT in the same cycle: stall wins, and HALT is re-evaluated once the hazard clears.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: o_flush_if_id is always 0, and the instruction after a taken transfer executes (delay slot).
- Undefined: a taken transfer asserts o_flush_if_id for exactly that cycle.

## Structure
- Shared package holds:
  - branch flag encodings (FLAG_NONE … FLAG_JUMP)
  - PC_SEL_* constants
  - state encoding
  - CANT_CICLOS_DRAIN default
- Sub-module hazard_detector: purely combinational register-match logic producing the hazard signal. The FSM and counters stay in hazard_control_unit.

## Test plan
- EX load writes $5, ID reads rs = $5 → exactly 1 stall cycle, o_stall_cycles = 1, no flush.
- BEQ $3,$4 with EX load writing $4 → 2 stall cycles, then pc_select = 01, flush = 1 (0 with BRANCH_DELAY_SLOT_EN).
- BNE with i_branch_equal = 1, no hazard → pc_select = 00, flush = 0; JR $31 → pc_select = 11, flush = 1.
- EX load writes $0 and ID reads $0 → no stall.
- HALT accepted at cycle t → stall/bubble held, o_halted = 1 at t+4. Dropping i_enable for 2 cycles mid-drain → o_halted at t+6.
- Reset asserted during DRAIN → next cycle RUN, all outputs 0, o_stall_cycles = 0.
